// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the multiply/divide unit: operation encodings and
// small decode helpers used by the top level.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  // Divide operations have the upper encoding bit set.
  function automatic logic op_is_div(input md_op_e op);
    return op[1];
  endfunction

  // Signed operations have the low encoding bit clear.
  function automatic logic op_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Launch/result bundle between the EX stage and the multiply/divide unit.
//
// Handshake: the pipeline raises start for one cycle with op/a/b stable;
// the unit accepts it only when idle or in its done cycle (busy low) and
// abort is low. busy then stays high until the result cycle, in which
// done pulses for one cycle and hi/lo/div_by_zero become valid and stay
// valid until the next committed result. abort cancels an accepted
// operation without producing done.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, abort,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, abort,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit_negate.sv
// Conditional two's-complement negate, used both to take operand
// magnitudes and to restore the sign of results.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit producing HI/LO.
// One FSM: IDLE -> RUN (WIDTH iterations) -> SIGN (fix-up, commit) -> DONE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  muldiv_unit_if.slave      bus,
  output logic [1:0]        o_dbg_state
);
  import muldiv_unit_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;

  logic [CW-1:0]      r_cnt;
  // Multiply: {partial product high, multiplier / product low}.
  // Divide:   {partial remainder, dividend / quotient}.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_a_raw;     // unmodified dividend for divide-by-zero
  logic               r_is_div;
  logic               r_neg_lo;    // negate product / quotient
  logic               r_neg_hi;    // negate remainder
  logic               r_dbz;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz_out;
  logic               r_busy;
  logic               r_done;

  logic               w_idle_or_done;
  logic               w_accept;
  logic               w_signed;
  logic               w_is_div;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
  // abort wins over start, so a flushed launch is never accepted.
  assign w_accept       = bus.start && !bus.abort && w_idle_or_done;
  assign w_signed       = op_is_signed(md_op_e'(bus.op));
  assign w_is_div       = op_is_div(md_op_e'(bus.op));
  assign w_neg_a        = w_signed && bus.a[WIDTH-1];
  assign w_neg_b        = w_signed && bus.b[WIDTH-1];

  muldiv_negate #(.W(WIDTH)) u_abs_a (
    .i_val (bus.a),
    .i_neg (w_neg_a),
    .o_val (w_abs_a)
  );

  muldiv_negate #(.W(WIDTH)) u_abs_b (
    .i_val (bus.b),
    .i_neg (w_neg_b),
    .o_val (w_abs_b)
  );

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier bit is set, keeping the carry, then shift right one.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Restoring step: shift the next dividend bit into the remainder and
  // keep the difference only if it did not go negative. When the trial
  // fails the remainder is below the divisor, so its shifted MSB is zero.
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
  assign w_div_next  = w_div_trial[WIDTH]
                     ? {r_acc[2*WIDTH-2:0], 1'b0}
                     : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  muldiv_negate #(.W(2*WIDTH)) u_fix_prod (
    .i_val (r_acc),
    .i_neg (r_neg_lo),
    .o_val (w_prod)
  );

  muldiv_negate #(.W(WIDTH)) u_fix_quo (
    .i_val (r_acc[WIDTH-1:0]),
    .i_neg (r_neg_lo),
    .o_val (w_quo)
  );

  muldiv_negate #(.W(WIDTH)) u_fix_rem (
    .i_val (r_acc[2*WIDTH-1:WIDTH]),
    .i_neg (r_neg_hi),
    .o_val (w_rem)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.abort)          w_state_nxt = S_IDLE;
        else if (r_cnt == '0)   w_state_nxt = S_SIGN;
      end
      S_SIGN: w_state_nxt = bus.abort ? S_IDLE : S_DONE;
      S_DONE: w_state_nxt = w_accept ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture at acceptance and one datapath iteration per RUN cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_a_raw  <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= CW'(WIDTH - 1);
      r_is_div <= w_is_div;
      r_neg_lo <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      r_neg_hi <= w_signed && w_is_div && bus.a[WIDTH-1];
      r_dbz    <= w_is_div && (bus.b == '0);
      r_a_raw  <= bus.a;
      if (w_is_div) begin
        r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
        r_opnd <= w_abs_b;
      end else begin
        r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
        r_opnd <= w_abs_a;
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - CW'(1);
      r_acc <= r_is_div ? w_div_next : w_mul_next;
    end
  end

  // Registered outputs: status follows the next state, results commit
  // only on a non-aborted SIGN edge and otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz_out <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN) || (w_state_nxt == S_SIGN);
      r_done <= (w_state_nxt == S_DONE);
      if ((r_state == S_SIGN) && !bus.abort) begin
        r_dbz_out <= r_dbz;
        if (r_dbz) begin
          r_lo <= '1;
          r_hi <= r_a_raw;
        end else if (r_is_div) begin
          r_lo <= w_quo;
          r_hi <= w_rem;
        end else begin
          r_lo <= w_prod[WIDTH-1:0];
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz_out;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH = 32.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W   = 32;
  localparam int SW  = 2*W + 1;
  localparam int LAT = W + 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  muldiv_unit_if #(.WIDTH(W)) bus();
  logic [1:0] dbg_state;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [SW-1:0] exp_q[$];        // {div_by_zero, hi, lo}
  logic [W-1:0]  last_hi = '0;
  logic [W-1:0]  last_lo = '0;

  task automatic check_eq(input string tag, input logic [SW-1:0] got,
                          input logic [SW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model built from SystemVerilog arithmetic.
  function automatic logic [SW-1:0] model(input logic [1:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic signed [2*W-1:0] sp;
    logic [2*W-1:0]        up;
    logic signed [W-1:0]   sa;
    logic signed [W-1:0]   sb;
    logic signed [W-1:0]   sq;
    logic signed [W-1:0]   sr;
    logic [W-1:0]          min_v;
    sa    = a;
    sb    = b;
    min_v = {1'b1, {(W-1){1'b0}}};
    case (md_op_e'(op))
      MD_MULT: begin
        sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        return {1'b0, sp};
      end
      MD_MULTU: begin
        up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return {1'b0, up};
      end
      MD_DIV: begin
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        if (a == min_v && b == '1) return {1'b0, {W{1'b0}}, min_v};
        sq = sa / sb;
        sr = sa % sb;
        return {1'b0, sr, sq};
      end
      default: begin
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns just after the accepting edge.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Waits for done, counting cycles from the accepting edge (n0 cycles
  // already elapsed); returns at the negedge of the done cycle.
  task automatic wait_done(input int n0);
    int n;
    int busy_bad;
    bit seen;
    logic [SW-1:0] e;
    n        = n0;
    busy_bad = 0;
    seen     = 1'b0;
    while (!seen && n < LAT + 8) begin
      @(negedge clock);
      n++;
      if (bus.done) seen = 1'b1;
      else if (!bus.busy) busy_bad++;
    end
    check_eq("done_seen", SW'(seen), SW'(1));
    check_eq("latency", SW'(n), SW'(LAT));
    check_eq("busy_during_run", SW'(busy_bad), SW'(0));
    check_eq("busy_at_done", SW'(bus.busy), SW'(0));
    check_eq("sb_depth", SW'(exp_q.size()), SW'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("lo", SW'(bus.lo), SW'(e[W-1:0]));
      check_eq("hi", SW'(bus.hi), SW'(e[2*W-1:W]));
      check_eq("div_by_zero", SW'(bus.div_by_zero), SW'(e[2*W]));
      last_lo = e[W-1:0];
      last_hi = e[2*W-1:W];
    end
  endtask

  task automatic done_gone();
    @(negedge clock);
    check_eq("done_one_cycle", SW'(bus.done), SW'(0));
  endtask

  task automatic check_held(input string tag);
    check_eq({tag, "_hi"}, SW'(bus.hi), SW'(last_hi));
    check_eq({tag, "_lo"}, SW'(bus.lo), SW'(last_lo));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    logic [1:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    bus.start = 1'b0;
    bus.op    = 2'(MD_MULT);
    bus.a     = '0;
    bus.b     = '0;
    bus.abort = 1'b0;
    reset     = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("rst_busy", SW'(bus.busy), SW'(0));
    check_eq("rst_done", SW'(bus.done), SW'(0));
    check_eq("rst_hi", SW'(bus.hi), SW'(0));
    check_eq("rst_lo", SW'(bus.lo), SW'(0));
    check_eq("rst_dbz", SW'(bus.div_by_zero), SW'(0));
    check_eq("rst_state", SW'(dbg_state), SW'(0));

    // Signed multiply -3 * 7.
    exp_q.push_back({1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    launch(2'(MD_MULT), 32'hFFFF_FFFD, 32'd7);
    wait_done(0);
    done_gone();

    // Unsigned multiply, then a back-to-back divide started in the done cycle.
    exp_q.push_back({1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    launch(2'(MD_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0);
    exp_q.push_back({1'b0, 32'd2, 32'd14});
    launch(2'(MD_DIVU), 32'd100, 32'd7);
    wait_done(0);
    done_gone();

    // Signed divide with negative dividend, then overflow MIN / -1.
    exp_q.push_back({1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    launch(2'(MD_DIV), 32'hFFFF_FFF9, 32'd2);
    wait_done(0);
    exp_q.push_back({1'b0, 32'h0000_0000, 32'h8000_0000});
    launch(2'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0);

    // Divide by zero.
    exp_q.push_back({1'b1, 32'h0000_0064, 32'hFFFF_FFFF});
    launch(2'(MD_DIVU), 32'd100, 32'd0);
    wait_done(0);
    done_gone();
    repeat (5) @(negedge clock);
    check_held("idle_hold");
    check_eq("idle_dbz_hold", SW'(bus.div_by_zero), SW'(1));

    // Abort ten cycles into a multiply: no done, results retained.
    launch(2'(MD_MULTU), 32'd5, 32'd6);
    repeat (5) @(negedge clock);
    check_held("run_hold");
    repeat (5) @(negedge clock);
    bus.abort = 1'b1;
    @(posedge clock);
    #1 bus.abort = 1'b0;
    @(negedge clock);
    check_eq("abort_busy", SW'(bus.busy), SW'(0));
    check_eq("abort_state", SW'(dbg_state), SW'(0));
    dones = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done) dones++;
    end
    check_eq("abort_no_done", SW'(dones), SW'(0));
    check_held("abort_hold");

    // A second start while busy is ignored.
    exp_q.push_back(model(2'(MD_MULTU), 32'd1234, 32'd5678));
    launch(2'(MD_MULTU), 32'd1234, 32'd5678);
    repeat (4) @(negedge clock);
    bus.start = 1'b1;
    bus.op    = 2'(MD_DIV);
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    @(posedge clock);
    #1 bus.start = 1'b0;
    wait_done(4);
    done_gone();

    // Reset in the middle of RUN clears every output.
    launch(2'(MD_MULT), 32'h1234_5678, 32'h0000_0321);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("midrst_busy", SW'(bus.busy), SW'(0));
    check_eq("midrst_done", SW'(bus.done), SW'(0));
    check_eq("midrst_hi", SW'(bus.hi), SW'(0));
    check_eq("midrst_lo", SW'(bus.lo), SW'(0));
    check_eq("midrst_dbz", SW'(bus.div_by_zero), SW'(0));
    check_eq("midrst_state", SW'(dbg_state), SW'(0));
    last_hi = '0;
    last_lo = '0;

    // start together with abort in IDLE is not accepted.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.op    = 2'(MD_DIVU);
    bus.a     = 32'd50;
    bus.b     = 32'd5;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clock);
    check_eq("sa_busy", SW'(bus.busy), SW'(0));
    check_eq("sa_state", SW'(dbg_state), SW'(0));
    dones = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done || bus.busy) dones++;
    end
    check_eq("sa_no_activity", SW'(dones), SW'(0));
    check_held("sa_hold");

    // Random operations, chained back-to-back.
    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 3));
      else                           rb = $urandom;
      if ($urandom_range(0, 4) == 0) ra = {1'b1, {(W-1){1'b0}}};
      exp_q.push_back(model(rop, ra, rb));
      launch(rop, ra, rb);
      wait_done(0);
    end
    done_gone();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
